// File: rtl/ttl_serial_transmitter.sv
// ---------------------------------------------------------------------------
// ttl_serial_transmitter
//
// Parallel-in, framed serial-out transmitter. A WIDTH-bit word is captured on
// an accepted Load and sent LSB first on Q. Each frame is a low start bit, the
// data bits, then a high stop bit. Each bit lasts BIT_CLOCKS cycles of Clk.
//
// Parameters
//   WIDTH       data bits per frame (>= 1)
//   BIT_CLOCKS  Clk cycles per transmitted bit (>= 1)
//   DELAY_RISE  output rise delay of the simulation model (>= 0)
//   DELAY_FALL  output fall delay of the simulation model (>= 0)
//
// Ports
//   Clk    in   rising-edge clock
//   Clear  in   synchronous active-high reset, overrides everything
//   Load   in   start-frame request, honoured only while Ready=1
//   D      in   parallel data, captured on the accepting edge
//   Q      out  serial line, idles high
//   Ready  out  idle and able to accept Load
//   Frame  out  start, data or stop bit is on Q
//   Done   out  one-cycle pulse in the first idle cycle after a stop bit
//
// All outputs come straight from flops. No input reaches an output without
// passing through a register.
// ---------------------------------------------------------------------------
module ttl_serial_transmitter #(
    parameter int WIDTH      = 8,
    parameter int BIT_CLOCKS = 1,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic             Q,
    output logic             Ready,
    output logic             Frame,
    output logic             Done
);

    // Counter widths never drop below one bit, so BIT_CLOCKS=1 and WIDTH=1
    // still give legal vectors.
    localparam int PW = (BIT_CLOCKS > 1) ? $clog2(BIT_CLOCKS) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(BIT_CLOCKS - 1);
    localparam logic [IW-1:0] INDEX_LAST  = IW'(WIDTH - 1);

    // The delay parameters belong to the simulation model only. This
    // synthesizable view drives zero-delay registered outputs. The parameters
    // are still range-checked so that a bad instantiation is caught.
    if (WIDTH < 1 || BIT_CLOCKS < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
        $error("ttl_serial_transmitter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [PW-1:0]   period_r;
    logic [PW-1:0]   next_period_s;
    logic [IW-1:0]   index_r;
    logic [IW-1:0]   next_index_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] next_shift_s;
    logic            q_r;
    logic            next_q_s;
    logic            ready_r;
    logic            next_ready_s;
    logic            frame_r;
    logic            next_frame_s;
    logic            done_r;
    logic            next_done_s;
    logic            period_end_s;

    assign period_end_s = (period_r == PERIOD_LAST);

    // Next-state, counter and next-output logic. Outputs are computed one
    // cycle ahead so that they can be registered along with the state.
    always_comb begin
        next_state_s  = state_r;
        next_period_s = period_r;
        next_index_s  = index_r;
        next_shift_s  = shift_r;
        next_q_s      = q_r;
        next_ready_s  = ready_r;
        next_frame_s  = frame_r;
        next_done_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (Load) begin
                    next_state_s  = START;
                    next_shift_s  = D;
                    next_period_s = '0;
                    next_index_s  = '0;
                    next_q_s      = 1'b0;
                    next_ready_s  = 1'b0;
                    next_frame_s  = 1'b1;
                end else begin
                    next_q_s      = 1'b1;
                    next_ready_s  = 1'b1;
                    next_frame_s  = 1'b0;
                end
            end
            START: begin
                if (period_end_s) begin
                    // Present bit 0 and pre-shift so that shift_r[0] is
                    // always the next bit to send.
                    next_state_s  = DATA;
                    next_period_s = '0;
                    next_index_s  = '0;
                    next_q_s      = shift_r[0];
                    next_shift_s  = shift_r >> 1;
                end else begin
                    next_period_s = period_r + PW'(1);
                end
            end
            DATA: begin
                if (period_end_s) begin
                    next_period_s = '0;
                    if (index_r == INDEX_LAST) begin
                        next_state_s = STOP;
                        next_q_s     = 1'b1;
                    end else begin
                        next_index_s = index_r + IW'(1);
                        next_q_s     = shift_r[0];
                        next_shift_s = shift_r >> 1;
                    end
                end else begin
                    next_period_s = period_r + PW'(1);
                end
            end
            STOP: begin
                if (period_end_s) begin
                    next_state_s  = IDLE;
                    next_period_s = '0;
                    next_q_s      = 1'b1;
                    next_ready_s  = 1'b1;
                    next_frame_s  = 1'b0;
                    next_done_s   = 1'b1;
                end else begin
                    next_period_s = period_r + PW'(1);
                end
            end
            default: begin
                next_state_s  = IDLE;
                next_period_s = '0;
                next_index_s  = '0;
                next_q_s      = 1'b1;
                next_ready_s  = 1'b1;
                next_frame_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers. Clear abandons any frame in
    // flight and suppresses its Done pulse.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_r  <= IDLE;
            period_r <= '0;
            index_r  <= '0;
            shift_r  <= '0;
            q_r      <= 1'b1;
            ready_r  <= 1'b1;
            frame_r  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            period_r <= next_period_s;
            index_r  <= next_index_s;
            shift_r  <= next_shift_s;
            q_r      <= next_q_s;
            ready_r  <= next_ready_s;
            frame_r  <= next_frame_s;
            done_r   <= next_done_s;
        end
    end

    assign Q     = q_r;
    assign Ready = ready_r;
    assign Frame = frame_r;
    assign Done  = done_r;

endmodule
